// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if: command, response and Wishbone master signals of wb_cmd_master
interface wb_cmd_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
           wb_dat_i, wb_ack_i, wb_err_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
           wb_dat_o, wb_adr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
           wb_dat_i, wb_ack_i, wb_err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
           wb_dat_o, wb_adr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding command to Wishbone classic master with err/timeout reporting
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_n,
  wb_cmd_master_if.master   bus
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        ready_nx, valid_nx, err_nx, tmo_nx, cyc_nx, we_nx, done;
  logic [31:0] rdat_nx, adr_nx, wdat_nx;
  logic [3:0]  sel_nx;
  // ack/err in the last wait cycle still wins because the timeout flag is only set when neither is high
  assign done = bus.wb_err_i || bus.wb_ack_i || cnt == TMO;
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.cmd_ready_o   <= 1'b0;
      bus.rsp_valid_o   <= 1'b0;
      bus.rsp_dat_o     <= '0;
      bus.rsp_err_o     <= 1'b0;
      bus.rsp_timeout_o <= 1'b0;
      bus.wb_cyc_o      <= 1'b0;
      bus.wb_stb_o      <= 1'b0;
      bus.wb_we_o       <= 1'b0;
      bus.wb_adr_o      <= '0;
      bus.wb_dat_o      <= '0;
      bus.wb_sel_o      <= '0;
    end else begin
      state             <= state_nx;
      cnt               <= cnt_nx;
      bus.cmd_ready_o   <= ready_nx;
      bus.rsp_valid_o   <= valid_nx;
      bus.rsp_dat_o     <= rdat_nx;
      bus.rsp_err_o     <= err_nx;
      bus.rsp_timeout_o <= tmo_nx;
      bus.wb_cyc_o      <= cyc_nx;
      bus.wb_stb_o      <= cyc_nx;
      bus.wb_we_o       <= we_nx;
      bus.wb_adr_o      <= adr_nx;
      bus.wb_dat_o      <= wdat_nx;
      bus.wb_sel_o      <= sel_nx;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ready_nx = bus.cmd_ready_o;
    valid_nx = bus.rsp_valid_o;
    rdat_nx  = bus.rsp_dat_o;
    err_nx   = bus.rsp_err_o;
    tmo_nx   = bus.rsp_timeout_o;
    cyc_nx   = bus.wb_cyc_o;
    we_nx    = bus.wb_we_o;
    adr_nx   = bus.wb_adr_o;
    wdat_nx  = bus.wb_dat_o;
    sel_nx   = bus.wb_sel_o;
    case (state)
      IDLE: begin
        ready_nx = 1'b1;
        if (bus.cmd_valid_i && bus.cmd_ready_o) begin
          state_nx = BUS;
          ready_nx = 1'b0;
          cyc_nx   = 1'b1;
          cnt_nx   = 16'd1;
          we_nx    = bus.cmd_we_i;
          adr_nx   = bus.cmd_adr_i & ~32'h3;
          wdat_nx  = bus.cmd_dat_i;
          sel_nx   = bus.cmd_sel_i;
        end
      end
      BUS: begin
        if (done) begin
          state_nx = RESP;
          cyc_nx   = 1'b0;
          valid_nx = 1'b1;
          cnt_nx   = '0;
          err_nx   = bus.wb_err_i;
          tmo_nx   = !bus.wb_err_i && !bus.wb_ack_i;
          rdat_nx  = (bus.wb_ack_i && !bus.wb_err_i && !bus.wb_we_o) ? bus.wb_dat_i : '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          ready_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: scenario tasks plus randomized transactions checked against a response model
module tb_wb_cmd_master;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  wb_cmd_master_if bus();
  wb_cmd_master #(.TIMEOUT_CYCLES(T)) dut (.clk_i(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // kind: 0 ack only, 1 err only, 2 ack+err; rc: bus cycle of the reply, out of 1..T means none
  function automatic logic [33:0] model_rsp(input logic we, input int kind, input logic [31:0] rdata, input int rc);
    if (rc < 1 || rc > T) return {32'h0, 1'b0, 1'b1};
    if (kind != 0) return {32'h0, 1'b1, 1'b0};
    return {we ? 32'h0 : rdata, 1'b0, 1'b0};
  endfunction
  function automatic int model_cycles(input int rc);
    return (rc >= 1 && rc <= T) ? rc : T;
  endfunction
  task automatic idle_inputs();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wb_dat_i    = '0;
    bus.wb_ack_i    = 1'b0;
    bus.wb_err_i    = 1'b0;
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.cmd_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s cmd_ready_wait: cmd_ready_o=%b required 1", tag, bus.cmd_ready_o);
    end
  endtask
  task automatic run_txn(input string tag, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int rc, input int kind, input logic [31:0] rdata,
                         input int hold, input logic keep_valid);
    logic [33:0] exp;
    logic [31:0] exp_adr;
    int cyc_n;
    exp = model_rsp(we, kind, rdata, rc);
    exp_adr = {adr[31:2], 2'b00};
    wait_ready(tag);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i = we;
    bus.cmd_adr_i = adr;
    bus.cmd_dat_i = dat;
    bus.cmd_sel_i = sel;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = keep_valid;
    bus.cmd_we_i = 1'($urandom);
    bus.cmd_adr_i = $urandom;
    bus.cmd_dat_i = $urandom;
    bus.cmd_sel_i = 4'($urandom);
    cyc_n = 0;
    while (bus.wb_cyc_o && cyc_n < 300) begin
      cyc_n++;
      checks++;
      if ({bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.cmd_ready_o, bus.rsp_valid_o}
          !== {1'b1, we, exp_adr, dat, sel, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s bus_fields c%0d: stb=%b we=%b adr=%h dat=%h sel=%h rdy=%b vld=%b required stb=1 we=%b adr=%h dat=%h sel=%h rdy=0 vld=0",
                 tag, cyc_n, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o,
                 bus.cmd_ready_o, bus.rsp_valid_o, we, exp_adr, dat, sel);
      end
      if (cyc_n == rc) begin
        bus.wb_ack_i = (kind != 1);
        bus.wb_err_i = (kind != 0);
        bus.wb_dat_i = rdata;
      end else begin
        bus.wb_dat_i = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
    end
    checks++;
    if (cyc_n != model_cycles(rc)) begin
      errors++;
      $display("FAIL %s cyc_len: cyc high %0d cycles required %0d", tag, cyc_n, model_cycles(rc));
    end
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_dat_o, bus.rsp_err_o, bus.rsp_timeout_o, bus.wb_stb_o} !== {1'b1, exp, 1'b0}) begin
      errors++;
      $display("FAIL %s rsp: vld=%b dat=%h err=%b tmo=%b stb=%b required vld=1 dat=%h err=%b tmo=%b stb=0",
               tag, bus.rsp_valid_o, bus.rsp_dat_o, bus.rsp_err_o, bus.rsp_timeout_o, bus.wb_stb_o,
               exp[33:2], exp[1], exp[0]);
    end
    for (int i = 0; i < hold; i++) begin
      bus.wb_ack_i = 1'($urandom);
      bus.wb_err_i = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid_o, bus.rsp_dat_o, bus.rsp_err_o, bus.rsp_timeout_o, bus.cmd_ready_o, bus.wb_cyc_o}
          !== {1'b1, exp, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s hold%0d: vld=%b dat=%h err=%b tmo=%b rdy=%b cyc=%b required vld=1 dat=%h err=%b tmo=%b rdy=0 cyc=0",
                 tag, i, bus.rsp_valid_o, bus.rsp_dat_o, bus.rsp_err_o, bus.rsp_timeout_o,
                 bus.cmd_ready_o, bus.wb_cyc_o, exp[33:2], exp[1], exp[0]);
      end
    end
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.cmd_valid_i = 1'b0;
    checks++;
    if ({bus.rsp_valid_o, bus.cmd_ready_o, bus.wb_cyc_o} !== 3'b010) begin
      errors++;
      $display("FAIL %s handshake: vld=%b rdy=%b cyc=%b required vld=0 rdy=1 cyc=0",
               tag, bus.rsp_valid_o, bus.cmd_ready_o, bus.wb_cyc_o);
    end
  endtask
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus.cmd_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_dat_o, bus.rsp_err_o, bus.rsp_timeout_o, bus.wb_cyc_o,
         bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o} !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b rdat=%h err=%b tmo=%b cyc=%b stb=%b we=%b adr=%h wdat=%h sel=%h required all 0",
               bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_dat_o, bus.rsp_err_o, bus.rsp_timeout_o,
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: cmd_ready_o=%b required 0", bus.cmd_ready_o);
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    checks++;
    if ({bus.cmd_ready_o, bus.wb_cyc_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_cycle: rdy=%b cyc=%b required rdy=1 cyc=0", bus.cmd_ready_o, bus.wb_cyc_o);
    end
  endtask
  task automatic test_read();
    run_txn("read", 1'b0, 32'h0000_1007, 32'h0, 4'hf, 3, 0, 32'hDEAD_BEEF, 0, 1'b0);
  endtask
  task automatic test_write();
    run_txn("write", 1'b1, 32'h0000_0010, 32'h1234_5678, 4'h3, 1, 0, 32'hCAFE_F00D, 0, 1'b0);
  endtask
  task automatic test_error();
    run_txn("err_both", 1'b0, 32'h0000_2000, 32'h0, 4'hf, 2, 2, 32'h5555_AAAA, 0, 1'b0);
    run_txn("err_only", 1'b1, 32'h0000_2004, 32'h7777_0000, 4'h1, 1, 1, 32'h1111_2222, 0, 1'b0);
  endtask
  task automatic test_timeout();
    run_txn("timeout", 1'b0, 32'h0000_3000, 32'h0, 4'hf, 0, 0, 32'h9999_9999, 0, 1'b0);
    run_txn("ack_last", 1'b0, 32'h0000_3004, 32'h0, 4'hf, T, 0, 32'h0BAD_CAFE, 0, 1'b0);
    run_txn("err_last", 1'b0, 32'h0000_3008, 32'h0, 4'hf, T, 1, 32'h0BAD_CAFE, 0, 1'b0);
  endtask
  task automatic test_backpressure();
    run_txn("backpressure", 1'b0, 32'h0000_4002, 32'h0, 4'hc, 2, 0, 32'hA5A5_5A5A, 5, 1'b1);
  endtask
  task automatic test_reset_mid_bus();
    wait_ready("rst_bus");
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i = 1'b1;
    bus.cmd_adr_i = 32'h0000_5000;
    bus.cmd_dat_i = 32'hFEED_0001;
    bus.cmd_sel_i = 4'hf;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_bus_pre: cyc=%b required 1", bus.wb_cyc_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o, bus.cmd_ready_o} !== 4'b0) begin
      errors++;
      $display("FAIL rst_bus_async: cyc=%b stb=%b vld=%b rdy=%b required all 0",
               bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o, bus.cmd_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wb_ack_i = 1'b1;
      bus.wb_err_i = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.wb_cyc_o, bus.rsp_valid_o, bus.cmd_ready_o} !== 3'b001) begin
        errors++;
        $display("FAIL rst_bus_stray%0d: cyc=%b vld=%b rdy=%b required cyc=0 vld=0 rdy=1",
                 i, bus.wb_cyc_o, bus.rsp_valid_o, bus.cmd_ready_o);
      end
    end
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i = 1'b0;
    bus.cmd_adr_i = 32'h0000_6000;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h1357_9BDF;
    @(posedge clk);
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_dat_o} !== {1'b1, 32'h1357_9BDF}) begin
      errors++;
      $display("FAIL rst_resp_pre: vld=%b dat=%h required vld=1 dat=13579bdf", bus.rsp_valid_o, bus.rsp_dat_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_dat_o, bus.wb_cyc_o} !== '0) begin
      errors++;
      $display("FAIL rst_resp_async: vld=%b dat=%h cyc=%b required all 0", bus.rsp_valid_o, bus.rsp_dat_o, bus.wb_cyc_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_txn("random", 1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 2)), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_read();
    test_write();
    test_error();
    test_timeout();
    test_backpressure();
    test_reset_mid_bus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of bus cycles to wait for ack/err before abort (legal 1..65535).
REQ-002 The block SHALL use one clock, clk_i; reset is rst_n, asynchronous and active-low.
REQ-003 clk_i  input  1  system clock.
REQ-004 rst_n  input  1  async active-low reset.
REQ-005 cmd_valid_i  input  1  command request.
REQ-006 cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-007 cmd_we_i  input  1  1=write, 0=read.
REQ-008 cmd_adr_i  input  32  byte address.
REQ-009 cmd_dat_i  input  32  write data.
REQ-010 cmd_sel_i  input  4  byte selects.
REQ-011 rsp_valid_o  output  1  response available.
REQ-012 rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-013 rsp_dat_o  output  32  read data (0 for writes, err, timeout).
REQ-014 rsp_err_o  output  1  slave signalled wb_err.
REQ-015 rsp_timeout_o  output  1  no ack/err within TIMEOUT_CYCLES.
REQ-016 wb_dat_o / wb_adr_o / wb_sel_o  output  32/32/4  Wishbone master write data, address, selects.
REQ-017 wb_we_o / wb_cyc_o / wb_stb_o  output  1/1/1  Wishbone master controls.
REQ-018 wb_dat_i / wb_ack_i / wb_err_i  input  32/1/1  Wishbone slave return path.

Function
REQ-019 The block SHALL implement FSM states IDLE, BUS, RESP; all outputs registered.
REQ-020 IDLE: cmd_ready_o=1, wb_cyc_o=wb_stb_o=0, rsp_valid_o=0; on cmd_valid_i the block SHALL latch we/adr/dat/sel and enter BUS.
REQ-021 Command accepted at edge N: wb_cyc_o and wb_stb_o SHALL be high from cycle N+1 and held high together through BUS.
REQ-022 wb_adr_o SHALL equal {cmd_adr_i[31:2],2'b00}; wb_dat_o, wb_sel_o, wb_we_o SHALL equal latched values, stable throughout BUS.
REQ-023 cmd_ready_o SHALL be 0 in BUS and RESP; only one transaction outstanding.
REQ-024 BUS: a 16-bit wait counter SHALL start at 1 in the first BUS cycle and increment each BUS cycle without ack/err.
REQ-025 wb_ack_i high in a BUS cycle: capture wb_dat_i (reads) or 0 (writes) into rsp_dat_o, rsp_err_o=0, rsp_timeout_o=0, go RESP.
REQ-026 wb_err_i high in a BUS cycle: rsp_dat_o=0, rsp_err_o=1, go RESP; if ack and err are both high, err SHALL take priority.
REQ-027 No ack/err by the end of BUS cycle TIMEOUT_CYCLES: rsp_timeout_o=1, rsp_dat_o=0, go RESP; ack/err in cycle TIMEOUT_CYCLES SHALL win over timeout.
REQ-028 On leaving BUS (ack/err in cycle M or timeout), wb_cyc_o/wb_stb_o SHALL be 0 and rsp_valid_o 1 from cycle M+1.
REQ-029 RESP: rsp_valid_o and response fields SHALL hold stable until rsp_ready_i; on handshake return to IDLE (cmd_ready_o=1 next cycle).
REQ-030 wb_ack_i/wb_err_i while in IDLE or RESP SHALL be ignored.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE, cmd_ready_o=0 during reset and 1 the first cycle after release, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, rsp_timeout_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, wb_sel_o=0, counter=0.
REQ-032 Reset asserted mid-BUS or mid-RESP SHALL drop wb_cyc_o/wb_stb_o and rsp_valid_o immediately; the in-flight transaction is discarded.

Verification
REQ-033 Read: cmd adr=0x0000_1007 we=0, slave acks 2 cycles later with 0xDEAD_BEEF -> wb_adr_o=0x0000_1004, rsp_dat_o=0xDEAD_BEEF, err=0, timeout=0.
REQ-034 Write: adr=0x0000_0010, dat=0x1234_5678, sel=0x3, zero-wait ack -> wb_we_o=1, wb_dat_o=0x1234_5678, rsp_dat_o=0, cyc high exactly 1 cycle.
REQ-035 Error: slave asserts ack and err together -> rsp_err_o=1, rsp_dat_o=0.
REQ-036 Timeout: TIMEOUT_CYCLES=4, no ack -> cyc/stb high exactly 4 cycles, rsp_timeout_o=1; variant with ack in cycle 4 -> timeout=0.
REQ-037 Backpressure: rsp_ready_i held low 5 cycles with cmd_valid_i high -> rsp fields stable, cmd_ready_o=0, no second bus cycle until handshake.
REQ-038 Reset mid-BUS: rst_n low during cycle 2 of BUS -> wb_cyc_o=0 and rsp_valid_o=0 without a clock edge; later stray wb_ack_i ignored.
